serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse, result valid (DONE state).
REQ-010 sum  output  WIDTH  result, valid from done until the next accepted start.
REQ-011 cout  output  1  carry-out, same validity as sum.

Function
REQ-012 Block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, through a 1-bit full adder built from two gate-level half adders plus an OR of their carries.
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE; no other reachable state.
REQ-014 IDLE: start=1 at a rising edge SHALL latch a, b into shift registers, cin into the carry register, clear the bit counter, and move to RUN.
REQ-015 IDLE with start=0 SHALL hold state, sum and cout unchanged.
REQ-016 RUN: each edge SHALL add the current LSBs of the A/B shift registers with the carry register, shift the sum bit into the MSB of the result shift register (right shift), shift A/B right by one, update carry, increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1 the FSM SHALL move to DONE and the final carry SHALL load cout.
REQ-018 DONE SHALL last exactly one cycle, then move to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k -> busy=1 for cycles following edges k..k+WIDTH-1, done=1 for the cycle following edge k+WIDTH; earliest new start accepted at edge k+WIDTH+2.
REQ-020 start asserted in RUN or DONE SHALL be ignored (no queuing); a, b, cin changes in RUN SHALL not affect the result.
REQ-021 busy and done SHALL be registered/decoded from state only, never combinationally from start.
REQ-022 sum and cout SHALL hold their last result through IDLE; internal partial sums SHALL not be visible on sum before done (use a separate result register loaded at RUN->DONE, or equivalent).
REQ-023 Overflow SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-024 Bit counter width SHALL be clog2(WIDTH) bits minimum and SHALL not wrap within RUN.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry and shift registers 0, regardless of clock.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release first rising edge with start=1 SHALL begin a fresh operation.
REQ-027 Release of rst_n SHALL be synchronised by the user; block assumes release not coincident with a rising edge.

Verification (WIDTH=8)
REQ-028 a=0x03, b=0x05, cin=0, start 1 cycle -> busy 8 cycles, done 1 cycle, sum=0x08, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 start held high continuously with a=0x10, b=0x20 -> operations accepted every 10 cycles, each sum=0x30; start/operand changes during RUN ignored.
REQ-031 Reset pulsed at 4th RUN cycle -> busy,done,sum,cout=0 at once, no done pulse; next start a=0x7F,b=0x01 -> sum=0x80, cout=0.
REQ-032 Idle 20 cycles after a result -> sum/cout hold value, done stays 0; randomised 1000 operand pairs incl. cin checked against a+b+cin reference model.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/operand request and busy/done/result bundle for serial_adder_ctrl
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder computing {cout,sum} = a + b + cin, one bit per clock
module serial_adder_ctrl #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, sum_q;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;
    logic             s1, c1, s_bit, c2, c_nxt, last;
    // full adder: two gate-level half adders, carries merged by an OR
    xor g_s1 (s1, a_sh[0], b_sh[0]);
    and g_c1 (c1, a_sh[0], b_sh[0]);
    xor g_s2 (s_bit, s1, carry);
    and g_c2 (c2, s1, carry);
    or  g_co (c_nxt, c1, c2);
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (bus.start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    // result register loads only on the final bit so partial sums never reach the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {s_bit, r_sh[WIDTH-1:1]};
            carry <= c_nxt;
            cnt   <= last ? cnt : cnt + 1'b1;
            if (last) begin
                sum_q  <= {s_bit, r_sh[WIDTH-1:1]};
                cout_q <= c_nxt;
            end
        end
    end
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
